rram_mvm_sequencer: RTL

Sequencer that runs one matrix-vector multiply on the RRAM crossbar core per command. It streams a 1024-bit input vector into the core's WL registers as 32 words and fires the read. It then waits for the core's conversion-valid, steps the ADC column-select through every phase, and returns each 32×4-bit ADC snapshot on a valid/ready result stream. It sits between the host-side command/data buses and the crossbar core, and owns the core's WR_WL, RE, ADDR, DATAIN, ADCSEL and handshake pins during inference.

---
 rtl/rram_ctrl_pkg.sv | 30 +++
 rtl/rram_sync2.sv | 25 ++
 rtl/rram_mvm_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rram_ctrl_pkg.sv
// Shared definitions for the RRAM crossbar control slice.
//   seq_state_t     : MVM sequencer FSM state encoding
//   WORD_IDX_W      : width of the input-vector word index
//   ADCSEL_W        : width of the core ADCSEL phase field
//   ADC_BITS        : bits per ADC channel in the core ADCout bus
//   ADDR_WORD_SHIFT : position of the word index inside core ADDR
//   word_addr()     : builds the core ADDR for a given input word
package rram_ctrl_pkg;

  localparam int unsigned WORD_IDX_W      = 5;
  localparam int unsigned ADCSEL_W        = 4;
  localparam int unsigned ADC_BITS        = 4;
  localparam int unsigned ADDR_WORD_SHIFT = 5;
  localparam int unsigned CORE_ADDR_W     = WORD_IDX_W + ADDR_WORD_SHIFT;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FIRE = 3'd2,
    ST_WAIT = 3'd3,
    ST_SCAN = 3'd4,
    ST_CAPT = 3'd5,
    ST_DONE = 3'd6
  } seq_state_t;

  function automatic logic [CORE_ADDR_W-1:0] word_addr(input logic [WORD_IDX_W-1:0] idx);
    return CORE_ADDR_W'(idx) << ADDR_WORD_SHIFT;
  endfunction

endpackage

// File: rtl/rram_sync2.sv
// Two-flop synchronizer bringing the core's CLK_ADC-domain valid into CLK.
//   CLK   : destination clock
//   RESET : synchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (two CLK cycles of latency)
module rram_sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rram_mvm_sequencer.sv
// Runs one matrix-vector multiply on the RRAM crossbar core per command:
// streams NUM_WORDS input words into the WL registers, fires the read, waits
// for the core's conversion valid, then walks ADCSEL through NUM_SEL phases
// and returns each ADC snapshot on a valid/ready result stream.
//   CLK, RESET          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : start handshake (ready only in IDLE)
//   in_valid/in_ready/in_data : input-vector word stream, word 0 first
//   core_*              : crossbar core control/data pins
//   res_valid/res_ready/res_data/res_sel/res_last : result snapshot stream
//   busy, done, err     : status (done/err are one-cycle pulses)
module rram_mvm_sequencer
  import rram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 32,
  parameter int unsigned NUM_ADCS   = 32,
  parameter int unsigned NUM_SEL    = 16,
  parameter int unsigned ADC_SETTLE = 2,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  output logic                         core_wr_wl,
  output logic                         core_wr_bl,
  output logic                         core_we,
  output logic                         core_re,
  output logic [CORE_ADDR_W-1:0]       core_addr,
  output logic [31:0]                  core_datain,
  output logic                         core_valid_i,
  input  logic                         core_ready_i,
  input  logic                         core_valid_o,
  output logic                         core_ready_o,
  output logic [ADCSEL_W-1:0]          core_adcsel,
  input  logic [ADC_BITS*NUM_ADCS-1:0] core_adcout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ADC_BITS*NUM_ADCS-1:0] res_data,
  output logic [ADCSEL_W-1:0]          res_sel,
  output logic                         res_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned SETTLE_W = (ADC_SETTLE > 1) ? $clog2(ADC_SETTLE + 1) : 1;
  localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);

  localparam logic [WORD_IDX_W-1:0] LAST_WORD  = WORD_IDX_W'(NUM_WORDS - 1);
  localparam logic [ADCSEL_W-1:0]   LAST_SEL   = ADCSEL_W'(NUM_SEL - 1);
  localparam logic [SETTLE_W-1:0]   SETTLE_END = SETTLE_W'(ADC_SETTLE - 1);
  localparam logic [TO_W-1:0]       TO_END     = TO_W'(TIMEOUT - 1);

  seq_state_t            state;
  logic [WORD_IDX_W-1:0] word_idx;
  logic [ADCSEL_W-1:0]   sel;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  armed;
  logic                  valid_sync;
  logic                  word_xfer;

  rram_sync2 u_valid_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (core_valid_o),
    .q     (valid_sync)
  );

  // armed holds cmd_ready low for the first cycle out of reset.
  assign cmd_ready    = (state == ST_IDLE) && armed;
  assign busy         = (state != ST_IDLE);
  assign in_ready     = (state == ST_LOAD) && core_ready_i;
  assign word_xfer    = in_valid && in_ready;
  assign core_ready_o = (state == ST_WAIT);
  assign res_valid    = (state == ST_CAPT);
  assign res_last     = res_valid && (res_sel == LAST_SEL);
  assign core_wr_bl   = 1'b0;
  assign core_we      = 1'b0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      word_idx     <= '0;
      sel          <= '0;
      settle_cnt   <= '0;
      to_cnt       <= '0;
      core_wr_wl   <= 1'b0;
      core_valid_i <= 1'b0;
      core_re      <= 1'b0;
      core_addr    <= '0;
      core_datain  <= '0;
      core_adcsel  <= '0;
      res_data     <= '0;
      res_sel      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      armed        <= 1'b1;
      core_wr_wl   <= 1'b0;
      core_valid_i <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid && armed) begin
            word_idx <= '0;
            state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (word_xfer) begin
            core_wr_wl   <= 1'b1;
            core_valid_i <= 1'b1;
            core_datain  <= in_data;
            core_addr    <= word_addr(word_idx);
            if (word_idx == LAST_WORD) begin
              word_idx <= '0;
              state    <= ST_FIRE;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end

        ST_FIRE: begin
          core_re <= 1'b1;
          to_cnt  <= '0;
          state   <= ST_WAIT;
        end

        // A synchronized valid is checked before the timeout so it wins a tie.
        ST_WAIT: begin
          if (valid_sync) begin
            sel         <= '0;
            core_adcsel <= '0;
            settle_cnt  <= '0;
            state       <= ST_SCAN;
          end else if (to_cnt == TO_END) begin
            err     <= 1'b1;
            core_re <= 1'b0;
            state   <= ST_IDLE;
          end else if (to_cnt < TO_END) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_SCAN: begin
          if (settle_cnt == SETTLE_END) begin
            res_data <= core_adcout;
            res_sel  <= sel;
            state    <= ST_CAPT;
          end else if (settle_cnt < SETTLE_END) begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        // ADCSEL only moves on the way back into SCAN, so it stays put
        // for as long as the result is held.
        ST_CAPT: begin
          if (res_ready) begin
            if (sel == LAST_SEL) begin
              sel     <= '0;
              core_re <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              sel         <= sel + 1'b1;
              core_adcsel <= sel + 1'b1;
              settle_cnt  <= '0;
              state       <= ST_SCAN;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
